vx_issue_dist: RTL and testbench
================================

# vx_issue_dist

Buffered decode-to-issue distributor between the decode stage and the `ISSUE_WIDTH` issue slices. It steers each decoded instruction to its slice with static mapping: slice = wid mod ISSUE_WIDTH, local warp = wid / ISSUE_WIDTH. Each slice has its own elastic FIFO, so a stalled slice no longer blocks the others. A per-warp occupancy cap bounds how much of a slice FIFO one warp can hold. The block also emits per-warp ibuf_pop pulses and per-slice stall counters.

## Interface
- ISSUE_WIDTH, 1: number of issue slices; power of 2, ≤ NUM_WARPS.
- NUM_WARPS, 4: total warps; power of 2.
- DATAW, 128: opaque decode payload width (uuid, tmask, PC, ex/op fields, wb, rd, rs1-3).
- FIFO_DEPTH, 4: entries per slice FIFO; power of 2, ≥ 2.
- WARP_MAX, 2: maximum entries one warp may hold in its slice FIFO; 1 ≤ WARP_MAX ≤ FIFO_DEPTH.
- PERF_W, 16: width of each stall counter.
- Derived: WID_W = clog2(NUM_WARPS), PER_WARPS = NUM_WARPS/ISSUE_WIDTH, WIS_W = max(1, clog2(PER_WARPS)).
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode entry valid.
- in_wid  in  WID_W  global warp id.
- in_data  in  DATAW  payload.
- in_ready  out  1  entry accepted this cycle when in_valid && in_ready.
- out_valid  out  ISSUE_WIDTH  per-slice head valid.
- out_wid  out  ISSUE_WIDTH×WIS_W  per-slice local warp id of head.
- out_data  out  ISSUE_WIDTH×DATAW  per-slice head payload.
- out_ready  in  ISSUE_WIDTH  per-slice consumer ready.
- ibuf_pop  out  NUM_WARPS  one-cycle pulse, indexed by global wid, when that warp's entry leaves a slice.
- stall_cnt  out  ISSUE_WIDTH×PERF_W  per-slice saturating stall counters.

## Operation
- Target slice s = in_wid[clog2(ISSUE_WIDTH)-1:0]. Local warp = in_wid >> clog2(ISSUE_WIDTH). When ISSUE_WIDTH = 1, s = 0.
- in_ready = !full[s] && (warp_cnt[in_wid] < WARP_MAX). It is combinational from registered state only, with no path from in_valid.
- Push: in_valid && in_ready writes {local wid, in_data} into FIFO s and increments warp_cnt[in_wid].
- Pop of slice k: out_valid[k] && out_ready[k]. It removes the head, decrements warp_cnt of that head's global wid (local·ISSUE_WIDTH + k), and pulses ibuf_pop for that global wid.
- Push and pop of the same warp in the same cycle leave warp_cnt unchanged. A push to a full FIFO with a same-cycle pop is not accepted, because in_ready uses the current full flag.
- Slices operate independently. Every slice may pop in the same cycle. Only one push occurs per cycle.
- Each FIFO preserves order. Read and write pointers are (clog2(FIFO_DEPTH)+1) bits wide, with a wrap bit. full = pointers differ only in the MSB. empty = pointers equal.
- stall_cnt[s] increments when in_valid && target == s && !in_ready. It saturates at 2^PERF_W−1 and never wraps.
- warp_cnt width is clog2(WARP_MAX+1). It never exceeds WARP_MAX and never underflows. An underflow attempt is an assertion failure.

## Timing
- Reset (async assert, sync release) clears all pointers, warp_cnt, and stall_cnt. After reset: out_valid = 0, ibuf_pop = 0, stall_cnt = 0, out_wid/out_data = 0, in_ready = 1.
- Latency: an entry pushed at cycle t is visible as out_valid at t+1. There is no combinational bypass.
- Throughput: 1 push/cycle total, 1 pop/cycle per slice.
- out_valid is high only when the FIFO is non-empty. out_data and out_wid are stable while out_valid && !out_ready.
- ibuf_pop is asserted in the same cycle as the pop handshake.
- Reset asserted mid-operation discards all buffered entries. No ibuf_pop is generated for discarded entries.

## Structure
- VX_gpu_pkg holds wid_to_isw / wid_to_wis and a new isw_wis_to_wid(isw, wis) for reconstructing the global wid.
- Sub-module vx_issue_dist_fifo: a single-slice FIFO with DATAW+WIS_W width, FIFO_DEPTH entries, and full/empty outputs. It is instantiated ISSUE_WIDTH times in a generate loop.
- The top level holds steering, the warp_cnt array, ibuf_pop generation, and stall counters.

## Test plan
- ISSUE_WIDTH=2, NUM_WARPS=4: push wids 0,1,2,3 back-to-back with out_ready=11 → slice0 emits local wids 0,1; slice1 emits local wids 0,1, each one cycle after its push; ibuf_pop pulses 0001, 0010, 0100, 1000.
- Hold out_ready[0]=0 and push wid 0 three times with WARP_MAX=2 → third push sees in_ready=0, and stall_cnt[0] counts each stalled cycle. Pushes of wid 1 to slice 1 still proceed.
- FIFO_DEPTH=4, WARP_MAX=4, out_ready=0: push 4 entries on wid 0 → in_ready=0. Release out_ready for 1 cycle → one pop, ibuf_pop[0]=1, and in_ready=1 the next cycle. Pointer wrap is exercised over 10 fill/drain rounds with order preserved.
- Same-cycle push and pop on wid 2 with warp_cnt=1 → warp_cnt stays 1 and the data order is intact.
- PERF_W=4 with a permanent stall → stall_cnt saturates at 15.
- Assert reset_n low with 3 entries buffered → out_valid=0 immediately and asynchronously, no ibuf_pop, and in_ready=1 after release.

Source files
------------

// File: rtl/vx_issue_dist_pkg.sv
// Shared helpers for mapping warps onto issue slices.
// Global wid = local wid * ISSUE_WIDTH + slice index.
package vx_issue_dist_pkg;

   function automatic int unsigned wid_to_isw(int unsigned wid, int unsigned issue_width);
      return wid % issue_width;
   endfunction

   function automatic int unsigned wid_to_wis(int unsigned wid, int unsigned issue_width);
      return wid / issue_width;
   endfunction

   function automatic int unsigned isw_wis_to_wid(int unsigned isw, int unsigned wis,
                                                  int unsigned issue_width);
      return wis * issue_width + isw;
   endfunction

endpackage

// File: rtl/vx_issue_dist_fifo.sv
// Single-slice elastic FIFO; pointers carry a wrap bit to separate full from empty.
module vx_issue_dist_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   always_comb begin
      empty_o  = (wr_ptr_q == rd_ptr_q);
      full_o   = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
      do_push  = push_i && !full_o;
      do_pop   = pop_i && !empty_o;
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
      // Empty slot reads as zero so the head is clean after reset.
      dout_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/vx_issue_dist.sv
// Decode-to-issue distributor: steers entries to per-slice FIFOs by wid,
// caps per-warp occupancy, and reports ibuf pops and per-slice stalls.
module vx_issue_dist
   import vx_issue_dist_pkg::*;
#(
   parameter int unsigned ISSUE_WIDTH = 1,
   parameter int unsigned NUM_WARPS   = 4,
   parameter int unsigned DATAW       = 128,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned WARP_MAX    = 2,
   parameter int unsigned PERF_W      = 16,
   localparam int unsigned WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int unsigned PER_WARPS  = NUM_WARPS / ISSUE_WIDTH,
   localparam int unsigned WIS_W      = (PER_WARPS > 1) ? $clog2(PER_WARPS) : 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          in_valid,
   input  logic [WID_W-1:0]              in_wid,
   input  logic [DATAW-1:0]              in_data,
   output logic                          in_ready,
   output logic [ISSUE_WIDTH-1:0]        out_valid,
   output logic [ISSUE_WIDTH*WIS_W-1:0]  out_wid,
   output logic [ISSUE_WIDTH*DATAW-1:0]  out_data,
   input  logic [ISSUE_WIDTH-1:0]        out_ready,
   output logic [NUM_WARPS-1:0]          ibuf_pop,
   output logic [ISSUE_WIDTH*PERF_W-1:0] stall_cnt
);
   localparam int unsigned ISW_W = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;
   localparam int unsigned CNT_W = $clog2(WARP_MAX + 1);
   localparam int unsigned ENT_W = DATAW + WIS_W;

   logic [ISSUE_WIDTH-1:0] full, empty, push, pop;
   logic [ENT_W-1:0]       head [ISSUE_WIDTH];
   logic [ISW_W-1:0]       in_isw;
   logic [WIS_W-1:0]       in_wis;
   logic [NUM_WARPS-1:0]   cnt_inc;
   logic [CNT_W-1:0]       warp_cnt_q [NUM_WARPS];
   logic [CNT_W-1:0]       warp_cnt_d [NUM_WARPS];
   logic [PERF_W-1:0]      stall_q [ISSUE_WIDTH];
   logic [PERF_W-1:0]      stall_d [ISSUE_WIDTH];

   always_comb begin
      in_isw   = ISW_W'(wid_to_isw(32'(in_wid), ISSUE_WIDTH));
      in_wis   = WIS_W'(wid_to_wis(32'(in_wid), ISSUE_WIDTH));
      in_ready = !full[in_isw] && (warp_cnt_q[in_wid] < CNT_W'(WARP_MAX));
      ibuf_pop = '0;
      for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
         push[k] = in_valid && in_ready && (in_isw == ISW_W'(k));
         pop[k]  = !empty[k] && out_ready[k];
         if (pop[k])
            ibuf_pop[WID_W'(isw_wis_to_wid(k, 32'(head[k][ENT_W-1 -: WIS_W]), ISSUE_WIDTH))] = 1'b1;
         out_valid[k]                   = !empty[k];
         out_wid[k*WIS_W +: WIS_W]      = head[k][ENT_W-1 -: WIS_W];
         out_data[k*DATAW +: DATAW]     = head[k][DATAW-1:0];
         stall_cnt[k*PERF_W +: PERF_W]  = stall_q[k];
         stall_d[k] = stall_q[k];
         if (in_valid && !in_ready && (in_isw == ISW_W'(k)) && (stall_q[k] != '1))
            stall_d[k] = stall_q[k] + PERF_W'(1);
      end
      // Simultaneous push and pop of one warp cancel out.
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
         cnt_inc[w]    = in_valid && in_ready && (in_wid == WID_W'(w));
         warp_cnt_d[w] = warp_cnt_q[w];
         if (cnt_inc[w] && !ibuf_pop[w])
            warp_cnt_d[w] = warp_cnt_q[w] + CNT_W'(1);
         else if (!cnt_inc[w] && ibuf_pop[w])
            warp_cnt_d[w] = warp_cnt_q[w] - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned w = 0; w < NUM_WARPS; w++) warp_cnt_q[w] <= '0;
         for (int unsigned k = 0; k < ISSUE_WIDTH; k++) stall_q[k] <= '0;
      end else begin
         for (int unsigned w = 0; w < NUM_WARPS; w++) warp_cnt_q[w] <= warp_cnt_d[w];
         for (int unsigned k = 0; k < ISSUE_WIDTH; k++) stall_q[k] <= stall_d[k];
      end
   end

   for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_slice
      vx_issue_dist_fifo #(
         .WIDTH (ENT_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk_i   (clk),
         .rst_ni  (reset_n),
         .push_i  (push[k]),
         .din_i   ({in_wis, in_data}),
         .pop_i   (pop[k]),
         .dout_o  (head[k]),
         .full_o  (full[k]),
         .empty_o (empty[k])
      );
   end

   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_chk
      a_no_underflow : assert property (@(posedge clk) disable iff (!reset_n)
         !(ibuf_pop[w] && !cnt_inc[w] && (warp_cnt_q[w] == '0)));
   end

endmodule

// File: tb/tb_vx_issue_dist.sv
// Scoreboard bench for vx_issue_dist: driver enqueues expected entries per slice,
// a negedge monitor compares heads, pops, in_ready and stall counters.
module tb_vx_issue_dist;
   localparam int unsigned IW = 2;
   localparam int unsigned NW = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned FD = 4;
   localparam int unsigned WM = 2;
   localparam int unsigned PW = 4;
   localparam int unsigned WIS_W = 1;
   localparam int unsigned SAT = (1 << PW) - 1;

   typedef struct {
      int unsigned gwid;
      logic [DW-1:0] data;
   } ent_t;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              in_valid = 1'b0;
   logic [1:0]        in_wid = '0;
   logic [DW-1:0]     in_data = '0;
   logic              in_ready;
   logic [IW-1:0]     out_valid;
   logic [IW*WIS_W-1:0] out_wid;
   logic [IW*DW-1:0]  out_data;
   logic [IW-1:0]     out_ready = '0;
   logic [NW-1:0]     ibuf_pop;
   logic [IW*PW-1:0]  stall_cnt;

   int unsigned checks = 0;
   int unsigned failures = 0;

   ent_t        sb [IW][$];
   int unsigned stall_m [IW];
   bit          exp_ready;
   bit          pend, pend_stall;
   ent_t        pend_e;
   int unsigned pend_s;
   bit          mon_en = 1'b0;
   logic [NW-1:0] m_eib;
   bit          m_v [IW];

   vx_issue_dist #(
      .ISSUE_WIDTH (IW),
      .NUM_WARPS   (NW),
      .DATAW       (DW),
      .FIFO_DEPTH  (FD),
      .WARP_MAX    (WM),
      .PERF_W      (PW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_wid    (in_wid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_wid   (out_wid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .ibuf_pop  (ibuf_pop),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Entry accepted iff slice queue has room and the warp holds fewer than WM entries.
   function automatic bit predict_ready(int unsigned w);
      int unsigned s = w % IW;
      int unsigned n = 0;
      foreach (sb[s][i]) if (sb[s][i].gwid == w) n++;
      return (sb[s].size() < FD) && (n < WM);
   endfunction

   task automatic commit();
      if (pend) sb[pend_e.gwid % IW].push_back(pend_e);
      if (pend_stall && stall_m[pend_s] < SAT) stall_m[pend_s]++;
      pend = 1'b0;
      pend_stall = 1'b0;
   endtask

   task automatic cycle(input bit v, input int unsigned w, input logic [DW-1:0] d,
                        input logic [IW-1:0] rdy);
      @(posedge clk);
      commit();
      #1;
      in_valid  = v;
      in_wid    = w[1:0];
      in_data   = d;
      out_ready = rdy;
      exp_ready = predict_ready(w);
      pend      = v && exp_ready;
      pend_e    = '{gwid: w, data: d};
      pend_stall = v && !exp_ready;
      pend_s    = w % IW;
   endtask

   task automatic do_reset();
      @(posedge clk);
      commit();
      #1;
      mon_en    = 1'b0;
      in_valid  = 1'b0;
      out_ready = '1;
      reset_n   = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_ibuf_pop", 64'(ibuf_pop), 64'd0);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_wid", 64'(out_wid), 64'd0);
      for (int k = 0; k < IW; k++) begin
         sb[k].delete();
         stall_m[k] = 0;
      end
      pend = 1'b0;
      pend_stall = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_hold_ibuf_pop", 64'(ibuf_pop), 64'd0);
      reset_n   = 1'b1;
      exp_ready = predict_ready(32'(in_wid));
      @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_rel_out_valid", 64'(out_valid), 64'd0);
      mon_en = 1'b1;
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (mon_en) begin
            m_eib = '0;
            for (int k = 0; k < IW; k++) begin
               m_v[k] = sb[k].size() > 0;
               chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(m_v[k]));
               if (m_v[k]) begin
                  chk($sformatf("out_wid[%0d]", k), 64'(out_wid[k*WIS_W +: WIS_W]),
                      64'(sb[k][0].gwid / IW));
                  chk($sformatf("out_data[%0d]", k), 64'(out_data[k*DW +: DW]),
                      64'(sb[k][0].data));
                  if (out_ready[k]) m_eib[sb[k][0].gwid] = 1'b1;
               end
            end
            chk("ibuf_pop", 64'(ibuf_pop), 64'(m_eib));
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            for (int k = 0; k < IW; k++)
               chk($sformatf("stall_cnt[%0d]", k), 64'(stall_cnt[k*PW +: PW]), 64'(stall_m[k]));
            for (int k = 0; k < IW; k++)
               if (m_v[k] && out_ready[k]) void'(sb[k].pop_front());
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin : driver
      do_reset();

      // Back-to-back pushes to both slices, consumers ready.
      for (int w = 0; w < 4; w++) cycle(1, w, 32'h100 + w, 2'b11);
      repeat (3) cycle(0, 0, '0, 2'b11);

      // Slice 0 blocked: warp cap on wid 0, slice 1 still flows.
      repeat (3) cycle(1, 0, $urandom, 2'b10);
      repeat (2) cycle(1, 1, $urandom, 2'b10);
      repeat (3) cycle(0, 0, '0, 2'b11);

      // Fill slice 0 completely, one-cycle release, then wrap rounds.
      cycle(1, 0, 32'hA0, 2'b00);
      cycle(1, 2, 32'hA1, 2'b00);
      cycle(1, 0, 32'hA2, 2'b00);
      cycle(1, 2, 32'hA3, 2'b00);
      cycle(1, 2, 32'hA4, 2'b00);
      cycle(0, 0, '0, 2'b01);
      cycle(1, 0, 32'hA5, 2'b00);
      repeat (5) cycle(0, 0, '0, 2'b01);
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < 4; i++) cycle(1, (i % 2) * 2, $urandom, 2'b00);
         repeat (4) cycle(0, 0, '0, 2'b01);
      end

      // Same-cycle push and pop on wid 2.
      cycle(1, 2, 32'hB0, 2'b00);
      cycle(1, 2, 32'hB1, 2'b01);
      cycle(1, 2, 32'hB2, 2'b00);
      cycle(1, 2, 32'hB3, 2'b00);
      repeat (4) cycle(0, 0, '0, 2'b11);

      // Permanent stall on slice 1 drives its counter to saturation.
      cycle(1, 1, $urandom, 2'b00);
      cycle(1, 3, $urandom, 2'b00);
      cycle(1, 1, $urandom, 2'b00);
      cycle(1, 3, $urandom, 2'b00);
      repeat (20) cycle(1, 1, $urandom, 2'b00);
      cycle(0, 0, '0, 2'b00);
      @(negedge clk);
      chk("stall_sat", 64'(stall_cnt[PW +: PW]), 64'(SAT));
      repeat (5) cycle(0, 0, '0, 2'b11);

      // Random traffic.
      for (int i = 0; i < 2000; i++)
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, NW - 1), $urandom,
               2'($urandom_range(0, 3)));
      repeat (6) cycle(0, 0, '0, 2'b11);

      // Reset with three entries buffered.
      cycle(1, 0, 32'hC0, 2'b00);
      cycle(1, 1, 32'hC1, 2'b00);
      cycle(1, 2, 32'hC2, 2'b00);
      cycle(0, 0, '0, 2'b00);
      do_reset();
      repeat (3) cycle(1, 3, $urandom, 2'b11);
      repeat (3) cycle(0, 0, '0, 2'b11);

      @(posedge clk);
      #1;
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
